blake2_pmod_host: RTL and testbench

- FPGA-side host driver for the BLAKE2 emulator's PMOD byte bus. Replaces the RPi PIO host.
- Takes a byte stream of config and message bytes and drives them onto the 8-bit data bus plus the 3-bit data_ctrl bus in 64-byte blocks, gated by the DUT ready signal.
- Pads the final block and captures the returned hash bytes (qualified by hash_v) into an output stream.
- Sits on the PMOD pins facing the emulator, or in a loopback bench on the same board.

---
 rtl/blake2_pmod_host.sv | 240 ++++++++++++++++++++++++
 tb/tb_blake2_pmod_host.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blake2_pmod_host.sv
// blake2_pmod_host: FPGA-side host for the BLAKE2 emulator PMOD byte bus.
// Streams config and message bytes onto data_o/data_ctrl_o in 64-byte blocks,
// gated by the synchronised ready line, pads the final block and collects the
// returned hash bytes (qualified by hash_v) into the rx stream.
// Optional feature: define BLAKE2_PMOD_HOST_TIMEOUT_EN to enable a watchdog on
// WAIT_RDY/WAIT_HASH that flags err_o and falls back to IDLE.
//
// Handshake: a tx byte transfers on a rising clk edge where tx_valid_i and
// tx_ready_o are both high; rx_valid_o is a one-cycle strobe with no
// backpressure. dbg_state_o exposes the FSM state for observation.
module blake2_pmod_host #(
    parameter int PMOD_W      = 8,
    parameter int BLOCK_BYTES = 64,
    parameter int HASH_BYTES  = 32,
    parameter int GUARD_CYC   = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst_async,
    input  logic [7:0]        tx_data_i,
    input  logic              tx_valid_i,
    input  logic              tx_cfg_i,
    input  logic              tx_last_i,
    output logic              tx_ready_o,
    output logic [7:0]        rx_data_o,
    output logic              rx_valid_o,
    output logic              rx_last_o,
    output logic              busy_o,
    output logic              err_o,
    input  logic [1:0]        lb_mode_i,
    output logic [PMOD_W-1:0] data_o,
    output logic [2:0]        data_ctrl_o,
    output logic [1:0]        loopback_ctrl_o,
    input  logic [PMOD_W-1:0] hash_i,
    input  logic [1:0]        hash_ctrl_i,
    output logic [2:0]        dbg_state_o
);

    localparam int IDX_W   = $clog2(BLOCK_BYTES);
    localparam int RXC_W   = $clog2(HASH_BYTES + 1);
    localparam int GRD_W   = $clog2(GUARD_CYC + 1);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(BLOCK_BYTES - 1);
    localparam logic [RXC_W-1:0] LAST_RX    = RXC_W'(HASH_BYTES - 1);
    localparam logic [GRD_W-1:0] LAST_GUARD = GRD_W'(GUARD_CYC - 1);

    // Pin codes on data_ctrl_o
    localparam logic [2:0] C_IDLE     = 3'b000;
    localparam logic [2:0] C_CFG      = 3'b001;
    localparam logic [2:0] C_DATA     = 3'b011;
    localparam logic [2:0] C_PAD      = 3'b101;
    localparam logic [2:0] C_DATA_END = 3'b111;
    localparam logic [2:0] C_PAD_END  = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_RDY  = 3'd1,
        S_BLOCK     = 3'd2,
        S_PAD       = 3'd3,
        S_GUARD     = 3'd4,
        S_WAIT_HASH = 3'd5,
        S_RX_HASH   = 3'd6
    } state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [RXC_W-1:0]    r_rx_cnt;
    logic [GRD_W-1:0]    r_guard;
    logic [PMOD_W-1:0]   r_data;
    logic [2:0]          r_ctrl;
    logic [1:0]          r_lb;
    logic [7:0]          r_rx_data;
    logic                r_rx_valid;
    logic                r_rx_last;
    logic                r_err;
    logic [PMOD_W-1:0]   r_hash_m;
    logic [PMOD_W-1:0]   r_hash_s;
    logic [1:0]          r_hctl_m;
    logic [1:0]          r_hctl_s;
    logic                w_rdy_s;
    logic                w_hv_s;

`ifdef BLAKE2_PMOD_HOST_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] LAST_TO = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0]     r_to_cnt;
`else
    // Watchdog limit has no effect in this build
    logic                w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYC == 0);
`endif

    assign w_rdy_s = r_hctl_s[0];
    assign w_hv_s  = r_hctl_s[1];

    assign tx_ready_o      = !rst_async &&
                             (((r_state == S_IDLE) && tx_cfg_i) || (r_state == S_BLOCK));
    assign busy_o          = (r_state != S_IDLE);
    assign err_o           = r_err;
    assign data_o          = r_data;
    assign data_ctrl_o     = r_ctrl;
    assign loopback_ctrl_o = r_lb;
    assign rx_data_o       = r_rx_data;
    assign rx_valid_o      = r_rx_valid;
    assign rx_last_o       = r_rx_last;
    assign dbg_state_o     = r_state;

    // Two-flop synchroniser for the asynchronous hash bus and register lb_mode to its pins
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            r_hash_m <= '0;
            r_hash_s <= '0;
            r_hctl_m <= '0;
            r_hctl_s <= '0;
            r_lb     <= '0;
        end else begin
            r_hash_m <= hash_i;
            r_hash_s <= r_hash_m;
            r_hctl_m <= hash_ctrl_i;
            r_hctl_s <= r_hctl_m;
            r_lb     <= lb_mode_i;
        end
    end

    // Main FSM: block transmit, padding, guard window and hash capture with registered pins
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_rx_cnt   <= '0;
            r_guard    <= '0;
            r_data     <= '0;
            r_ctrl     <= C_IDLE;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_last  <= 1'b0;
            r_err      <= 1'b0;
`ifdef BLAKE2_PMOD_HOST_TIMEOUT_EN
            r_to_cnt   <= '0;
`endif
        end else begin
            // Pins idle unless a byte is sent this cycle
            r_data     <= '0;
            r_ctrl     <= C_IDLE;
            r_rx_valid <= 1'b0;
            r_rx_last  <= 1'b0;

            // A hash strobe outside the hash window is a protocol error
            if (w_hv_s && (r_state != S_WAIT_HASH) && (r_state != S_RX_HASH))
                r_err <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (tx_valid_i) begin
                        if (tx_cfg_i) begin
                            r_data <= PMOD_W'(tx_data_i);
                            r_ctrl <= C_CFG;
                        end else begin
                            // Message byte stays pending until the block opens
                            r_state <= S_WAIT_RDY;
                        end
                    end
                end
                S_WAIT_RDY: begin
                    if (w_rdy_s) begin
                        r_idx   <= '0;
                        r_state <= S_BLOCK;
                    end
                end
                S_BLOCK: begin
                    if (tx_valid_i) begin
                        r_data <= PMOD_W'(tx_data_i);
                        r_idx  <= r_idx + IDX_W'(1);
                        if (tx_cfg_i)
                            r_err <= 1'b1;
                        if (tx_last_i && (r_idx == LAST_IDX)) begin
                            r_ctrl  <= C_DATA_END;
                            r_state <= S_WAIT_HASH;
                        end else begin
                            r_ctrl <= C_DATA;
                            if (tx_last_i) begin
                                r_state <= S_PAD;
                            end else if (r_idx == LAST_IDX) begin
                                r_guard <= '0;
                                r_state <= S_GUARD;
                            end
                        end
                    end
                end
                S_PAD: begin
                    r_idx <= r_idx + IDX_W'(1);
                    if (r_idx == LAST_IDX) begin
                        r_ctrl  <= C_PAD_END;
                        r_state <= S_WAIT_HASH;
                    end else begin
                        r_ctrl <= C_PAD;
                    end
                end
                S_GUARD: begin
                    // Ignore the stale synchronised ready while the DUT reacts
                    if (r_guard == LAST_GUARD)
                        r_state <= S_WAIT_RDY;
                    else
                        r_guard <= r_guard + GRD_W'(1);
                end
                S_WAIT_HASH, S_RX_HASH: begin
                    if (w_hv_s) begin
                        r_rx_data  <= 8'(r_hash_s);
                        r_rx_valid <= 1'b1;
                        if (r_rx_cnt == LAST_RX) begin
                            r_rx_last <= 1'b1;
                            r_rx_cnt  <= '0;
                            r_state   <= S_IDLE;
                        end else begin
                            r_rx_cnt <= r_rx_cnt + RXC_W'(1);
                            r_state  <= S_RX_HASH;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

`ifdef BLAKE2_PMOD_HOST_TIMEOUT_EN
            // Watchdog restarts on every entry to a waiting state
            if ((r_state == S_WAIT_RDY) || (r_state == S_WAIT_HASH)) begin
                if (r_to_cnt == LAST_TO) begin
                    r_to_cnt <= '0;
                    r_err    <= 1'b1;
                    r_state  <= S_IDLE;
                end else begin
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                end
            end else begin
                r_to_cnt <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_blake2_pmod_host.sv
// Directed bench for blake2_pmod_host: reset, single padded block, full block,
// two-block message with ready stall, stray hash strobe and mid-block reset.
`timescale 1ns/1ps
module tb_blake2_pmod_host;

    logic        clk = 1'b0;
    logic        rst_async = 1'b1;
    logic [7:0]  tx_data_i = '0;
    logic        tx_valid_i = 1'b0;
    logic        tx_cfg_i = 1'b0;
    logic        tx_last_i = 1'b0;
    logic        tx_ready_o;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        rx_last_o;
    logic        busy_o;
    logic        err_o;
    logic [1:0]  lb_mode_i = '0;
    logic [7:0]  data_o;
    logic [2:0]  data_ctrl_o;
    logic [1:0]  loopback_ctrl_o;
    logic [7:0]  hash_i = '0;
    logic [1:0]  hash_ctrl_i = '0;
    logic [2:0]  dbg_state_o;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [10:0] pin_q[$];
    logic [8:0]  rx_q[$];
    logic [10:0] exp_q[$];

    blake2_pmod_host dut (
        .clk             (clk),
        .rst_async       (rst_async),
        .tx_data_i       (tx_data_i),
        .tx_valid_i      (tx_valid_i),
        .tx_cfg_i        (tx_cfg_i),
        .tx_last_i       (tx_last_i),
        .tx_ready_o      (tx_ready_o),
        .rx_data_o       (rx_data_o),
        .rx_valid_o      (rx_valid_o),
        .rx_last_o       (rx_last_o),
        .busy_o          (busy_o),
        .err_o           (err_o),
        .lb_mode_i       (lb_mode_i),
        .data_o          (data_o),
        .data_ctrl_o     (data_ctrl_o),
        .loopback_ctrl_o (loopback_ctrl_o),
        .hash_i          (hash_i),
        .hash_ctrl_i     (hash_ctrl_i),
        .dbg_state_o     (dbg_state_o)
    );

    // Clock / reset
    always #12.5 clk = ~clk;

    // Pin and rx monitors sample on the falling edge
    always @(negedge clk) begin
        if (data_ctrl_o !== 3'b000)
            pin_q.push_back({data_ctrl_o, data_o});
        if (rx_valid_o === 1'b1)
            rx_q.push_back({rx_last_o, rx_data_o});
    end

    // Driver: present one tx byte and hold it until accepted
    task automatic send_byte(input logic [7:0] d, input logic c, input logic l);
        logic acc;
        acc = 1'b0;
        tx_data_i  = d;
        tx_cfg_i   = c;
        tx_last_i  = l;
        tx_valid_i = 1'b1;
        for (int n = 0; n < 300 && !acc; n++) begin
            #1;
            if (tx_ready_o === 1'b1) acc = 1'b1;
            @(negedge clk);
        end
        tx_valid_i = 1'b0;
        tx_cfg_i   = 1'b0;
        tx_last_i  = 1'b0;
        tx_data_i  = '0;
        if (!acc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_byte_timeout: byte %h not accepted, ready=%b want 1", d, tx_ready_o);
        end
    endtask

    // Driver: assert hash_v for 32 cycles with bytes base..base+31, ready held high
    task automatic drive_hash(input logic [7:0] base);
        rx_q.delete();
        for (int k = 0; k < 32; k++) begin
            hash_i      = base + 8'(k);
            hash_ctrl_i = 2'b11;
            @(negedge clk);
        end
        hash_ctrl_i = 2'b01;
        hash_i      = '0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_async = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tx_data_i   = 8'($urandom_range(0, 255));
            tx_valid_i  = 1'($urandom_range(0, 1));
            tx_cfg_i    = 1'($urandom_range(0, 1));
            tx_last_i   = 1'($urandom_range(0, 1));
            lb_mode_i   = 2'($urandom_range(0, 3));
            hash_i      = 8'($urandom_range(0, 255));
            hash_ctrl_i = 2'($urandom_range(0, 3));
            @(negedge clk);
            #1;
            n_cmp++;
            if ({tx_ready_o, rx_data_o, rx_valid_o, rx_last_o, busy_o, err_o,
                 data_o, data_ctrl_o, loopback_ctrl_o} !== 25'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: got rdy=%b rx=%h rv=%b rl=%b busy=%b err=%b d=%h c=%b lb=%b want all 0",
                         tx_ready_o, rx_data_o, rx_valid_o, rx_last_o, busy_o, err_o,
                         data_o, data_ctrl_o, loopback_ctrl_o);
            end
        end
        tx_valid_i  = 1'b0;
        tx_cfg_i    = 1'b0;
        tx_last_i   = 1'b0;
        tx_data_i   = '0;
        lb_mode_i   = 2'b00;
        hash_i      = '0;
        hash_ctrl_i = 2'b01;
        @(negedge clk);
        rst_async = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (data_ctrl_o !== 3'b000 || busy_o !== 1'b0 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got ctrl=%b busy=%b err=%b want 000 0 0", data_ctrl_o, busy_o, err_o);
        end
        lb_mode_i = 2'b10;
        @(negedge clk);
        n_cmp++;
        if (loopback_ctrl_o !== 2'b10) begin
            n_fail++;
            $display("FAIL loopback_reg: got %b want 10", loopback_ctrl_o);
        end
        lb_mode_i = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_abc;
        pin_q.delete();
        exp_q.delete();
        send_byte(8'h20, 1'b1, 1'b0);
        send_byte(8'h61, 1'b0, 1'b0);
        send_byte(8'h62, 1'b0, 1'b0);
        send_byte(8'h63, 1'b0, 1'b1);
        repeat (70) @(negedge clk);
        exp_q.push_back({3'b001, 8'h20});
        exp_q.push_back({3'b011, 8'h61});
        exp_q.push_back({3'b011, 8'h62});
        exp_q.push_back({3'b011, 8'h63});
        for (int i = 3; i < 63; i++) exp_q.push_back({3'b101, 8'h00});
        exp_q.push_back({3'b110, 8'h00});
        n_cmp++;
        if (pin_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL abc_pin_count: got %0d want %0d", pin_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < pin_q.size(); i++) begin
            n_cmp++;
            if (pin_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL abc_pin[%0d]: got ctrl=%b data=%h want ctrl=%b data=%h",
                         i, pin_q[i][10:8], pin_q[i][7:0], exp_q[i][10:8], exp_q[i][7:0]);
            end
        end
        n_cmp++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL abc_wait_hash_busy: got %b want 1", busy_o);
        end
        drive_hash(8'h00);
        n_cmp++;
        if (rx_q.size() !== 32) begin
            n_fail++;
            $display("FAIL abc_rx_count: got %0d want 32", rx_q.size());
        end
        for (int k = 0; k < 32 && k < rx_q.size(); k++) begin
            n_cmp++;
            if (rx_q[k] !== {(k == 31), 8'(k)}) begin
                n_fail++;
                $display("FAIL abc_rx[%0d]: got last=%b data=%h want last=%b data=%h",
                         k, rx_q[k][8], rx_q[k][7:0], (k == 31), 8'(k));
            end
        end
        n_cmp++;
        if (busy_o !== 1'b0 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abc_end_idle: got busy=%b err=%b want 0 0", busy_o, err_o);
        end
    endtask

    task automatic test_full_block;
        pin_q.delete();
        exp_q.delete();
        for (int i = 0; i < 64; i++) send_byte(8'(i + 8'h80), 1'b0, (i == 63));
        repeat (5) @(negedge clk);
        for (int i = 0; i < 63; i++) exp_q.push_back({3'b011, 8'(i + 8'h80)});
        exp_q.push_back({3'b111, 8'hBF});
        n_cmp++;
        if (pin_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL full_pin_count: got %0d want %0d", pin_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < pin_q.size(); i++) begin
            n_cmp++;
            if (pin_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL full_pin[%0d]: got ctrl=%b data=%h want ctrl=%b data=%h",
                         i, pin_q[i][10:8], pin_q[i][7:0], exp_q[i][10:8], exp_q[i][7:0]);
            end
        end
        n_cmp++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL full_wait_hash_busy: got %b want 1", busy_o);
        end
        drive_hash(8'h40);
        n_cmp++;
        if (rx_q.size() !== 32 || rx_q[rx_q.size()-1] !== {1'b1, 8'h5F}) begin
            n_fail++;
            $display("FAIL full_rx: got count=%0d want 32 ending last=1 data=5f", rx_q.size());
        end
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL full_end_idle: got busy=%b want 0", busy_o);
        end
    endtask

    task automatic test_two_blocks;
        int base;
        logic ok;
        pin_q.delete();
        exp_q.delete();
        for (int i = 0; i < 64; i++) send_byte(8'(i), 1'b0, 1'b0);
        hash_ctrl_i = 2'b00;
        @(negedge clk);
        base = pin_q.size();
        ok = 1'b1;
        fork
            send_byte(8'hA5, 1'b0, 1'b1);
            begin
                for (int c = 0; c < 10; c++) begin
                    #1;
                    if (tx_ready_o !== 1'b0 || pin_q.size() != base) ok = 1'b0;
                    @(negedge clk);
                end
                n_cmp++;
                if (!ok) begin
                    n_fail++;
                    $display("FAIL stall_no_send: got ready=%b sent=%0d want ready 0 sent %0d",
                             tx_ready_o, pin_q.size(), base);
                end
                hash_ctrl_i = 2'b01;
            end
        join
        repeat (70) @(negedge clk);
        for (int i = 0; i < 64; i++) exp_q.push_back({3'b011, 8'(i)});
        exp_q.push_back({3'b011, 8'hA5});
        for (int i = 1; i < 63; i++) exp_q.push_back({3'b101, 8'h00});
        exp_q.push_back({3'b110, 8'h00});
        n_cmp++;
        if (pin_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL two_pin_count: got %0d want %0d", pin_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < pin_q.size(); i++) begin
            n_cmp++;
            if (pin_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL two_pin[%0d]: got ctrl=%b data=%h want ctrl=%b data=%h",
                         i, pin_q[i][10:8], pin_q[i][7:0], exp_q[i][10:8], exp_q[i][7:0]);
            end
        end
        drive_hash(8'hC0);
        n_cmp++;
        if (rx_q.size() !== 32 || busy_o !== 1'b0 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL two_rx_end: got count=%0d busy=%b err=%b want 32 0 0", rx_q.size(), busy_o, err_o);
        end
    endtask

    task automatic test_hv_idle_err;
        rx_q.delete();
        hash_i      = 8'hEE;
        hash_ctrl_i = 2'b11;
        @(negedge clk);
        hash_ctrl_i = 2'b01;
        hash_i      = '0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (err_o !== 1'b1 || rx_q.size() != 0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL hv_idle_err: got err=%b rx=%0d busy=%b want 1 0 0", err_o, rx_q.size(), busy_o);
        end
        repeat (10) @(negedge clk);
        n_cmp++;
        if (err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got %b want 1", err_o);
        end
    endtask

    task automatic test_reset_mid_block;
        for (int i = 0; i < 20; i++) send_byte(8'(i + 8'h30), 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_block_busy: got %b want 1", busy_o);
        end
        rst_async = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (data_ctrl_o !== 3'b000 || busy_o !== 1'b0 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got ctrl=%b busy=%b err=%b want 000 0 0", data_ctrl_o, busy_o, err_o);
        end
        @(negedge clk);
        rst_async = 1'b0;
        repeat (3) @(negedge clk);
        pin_q.delete();
        exp_q.delete();
        send_byte(8'hA1, 1'b0, 1'b0);
        send_byte(8'hA2, 1'b0, 1'b0);
        send_byte(8'hA3, 1'b0, 1'b1);
        repeat (70) @(negedge clk);
        exp_q.push_back({3'b011, 8'hA1});
        exp_q.push_back({3'b011, 8'hA2});
        exp_q.push_back({3'b011, 8'hA3});
        for (int i = 3; i < 63; i++) exp_q.push_back({3'b101, 8'h00});
        exp_q.push_back({3'b110, 8'h00});
        n_cmp++;
        if (pin_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL restart_pin_count: got %0d want %0d", pin_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < pin_q.size(); i++) begin
            n_cmp++;
            if (pin_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL restart_pin[%0d]: got ctrl=%b data=%h want ctrl=%b data=%h",
                         i, pin_q[i][10:8], pin_q[i][7:0], exp_q[i][10:8], exp_q[i][7:0]);
            end
        end
        drive_hash(8'h10);
        n_cmp++;
        if (rx_q.size() !== 32 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_rx_end: got count=%0d busy=%b want 32 0", rx_q.size(), busy_o);
        end
    endtask

    // Sequence of scenarios and final report
    initial begin
        test_reset();
        test_abc();
        test_full_block();
        test_two_blocks();
        test_hv_idle_err();
        test_reset_mid_block();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Run-time bound
    initial begin
        #2ms;
        n_cmp++;
        n_fail++;
        $display("FAIL watchdog: simulation still running at 2ms, want finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
